// File: rtl/boss_attack_ctrl.sv
// Boss attack sequencer: fan/big bullet timing, phase tracking, player lives and invulnerability.
// Latency: all outputs are registered, one clk22 tick after the inputs that cause them.
// Backpressure: a busy slot parks the due timer at 0 until the slot frees; BOSS_ATTACK_ENRAGE_EN halves phase-2 periods.
module boss_attack_ctrl #(
    parameter int FAN_PERIOD   = 8,
    parameter int BIG_PERIOD   = 24,
    parameter int INVULN_TICKS = 16,
    parameter int LIVES        = 3
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       boss,
    input  logic [7:0] boss_hp,
    input  logic [5:0] slot_busy,
    input  logic       shot,
    output logic       fire_fan,
    output logic       fire_big,
    output logic [1:0] phase,
    output logic       invuln,
    output logic [2:0] life,
    output logic       game_over
);

    localparam int MAXP = (FAN_PERIOD > BIG_PERIOD) ? FAN_PERIOD : BIG_PERIOD;
    localparam int TW   = $clog2(MAXP + 1);
    localparam int IW   = $clog2(INVULN_TICKS + 1);

`ifdef BOSS_ATTACK_ENRAGE_EN
    localparam int FAN_FAST = (FAN_PERIOD / 2 < 1) ? 1 : FAN_PERIOD / 2;
    localparam int BIG_FAST = (BIG_PERIOD / 2 < 1) ? 1 : BIG_PERIOD / 2;
`else
    localparam int FAN_FAST = FAN_PERIOD;
    localparam int BIG_FAST = BIG_PERIOD;
`endif

    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   fan_tmr, fan_tmr_nxt, big_tmr, big_tmr_nxt;
    logic [TW-1:0]   fan_rel, big_rel;
    logic [IW-1:0]   inv_cnt, inv_cnt_nxt;
    logic [2:0]      life_nxt;
    logic [1:0]      phase_nxt;
    logic            fire_fan_nxt, fire_big_nxt, invuln_nxt, game_over_nxt;
    logic            hit, stay_run, fan_due, big_due;

    always_ff @(posedge clk22) begin
        if (rst) begin
            state     <= IDLE;
            fire_fan  <= 1'b0;
            fire_big  <= 1'b0;
            phase     <= 2'd0;
            invuln    <= 1'b0;
            inv_cnt   <= '0;
            life      <= 3'(LIVES);
            game_over <= 1'b0;
            fan_tmr   <= TW'(FAN_PERIOD - 1);
            big_tmr   <= TW'(BIG_PERIOD - 1);
        end else begin
            state     <= state_nxt;
            fire_fan  <= fire_fan_nxt;
            fire_big  <= fire_big_nxt;
            phase     <= phase_nxt;
            invuln    <= invuln_nxt;
            inv_cnt   <= inv_cnt_nxt;
            life      <= life_nxt;
            game_over <= game_over_nxt;
            fan_tmr   <= fan_tmr_nxt;
            big_tmr   <= big_tmr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fire_fan_nxt  = 1'b0;
        fire_big_nxt  = 1'b0;
        invuln_nxt    = invuln;
        inv_cnt_nxt   = inv_cnt;
        life_nxt      = life;
        game_over_nxt = game_over;
        fan_tmr_nxt   = fan_tmr;
        big_tmr_nxt   = big_tmr;

        if (boss_hp >= 8'd128)
            phase_nxt = 2'd0;
        else if (boss_hp >= 8'd64)
            phase_nxt = 2'd1;
        else
            phase_nxt = 2'd2;

        fan_rel = (phase == 2'd2) ? TW'(FAN_FAST - 1) : TW'(FAN_PERIOD - 1);
        big_rel = (phase == 2'd2) ? TW'(BIG_FAST - 1) : TW'(BIG_PERIOD - 1);

        hit      = (state == RUN) && boss && shot && !invuln && (life != 3'd0);
        stay_run = !(hit && (life == 3'd1));
        fan_due  = (fan_tmr == '0) && (slot_busy[5:1] == 5'd0);
        big_due  = (phase != 2'd0) && (big_tmr == '0) && !slot_busy[0] && !fan_due;

        // The window counts down in every state; a fresh hit below overrides it.
        if (invuln) begin
            if (inv_cnt != '0)
                inv_cnt_nxt = inv_cnt - IW'(1);
            else
                invuln_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (boss)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!boss) begin
                    state_nxt   = IDLE;
                    fan_tmr_nxt = TW'(FAN_PERIOD - 1);
                    big_tmr_nxt = TW'(BIG_PERIOD - 1);
                    invuln_nxt  = 1'b0;
                    inv_cnt_nxt = '0;
                end else begin
                    if (hit) begin
                        life_nxt    = life - 3'd1;
                        invuln_nxt  = 1'b1;
                        inv_cnt_nxt = IW'(INVULN_TICKS - 1);
                        if (life == 3'd1) begin
                            state_nxt     = OVER;
                            game_over_nxt = 1'b1;
                        end
                    end
                    if (fan_tmr != '0)
                        fan_tmr_nxt = fan_tmr - TW'(1);
                    if (big_tmr != '0)
                        big_tmr_nxt = big_tmr - TW'(1);
                    // A killing hit suppresses the launch so no pulse shows up in OVER.
                    if (stay_run && fan_due) begin
                        fire_fan_nxt = 1'b1;
                        fan_tmr_nxt  = fan_rel;
                    end
                    if (stay_run && big_due) begin
                        fire_big_nxt = 1'b1;
                        big_tmr_nxt  = big_rel;
                    end
                end
            end
            OVER: begin
                state_nxt = OVER;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_boss_attack_ctrl.sv
// Bench for boss_attack_ctrl: directed scenarios plus random traffic against an elapsed-time reference model.
module tb_boss_attack_ctrl;

    localparam int FAN_P = 8;
    localparam int BIG_P = 24;
    localparam int INV_T = 16;
    localparam int NLIFE = 3;

`ifdef BOSS_ATTACK_ENRAGE_EN
    localparam int EXP_FAN_GAP2 = 4;
    localparam int EXP_BIG_GAP2 = 12;
`else
    localparam int EXP_FAN_GAP2 = 8;
    localparam int EXP_BIG_GAP2 = 24;
`endif

    logic       clk22 = 1'b0;
    logic       rst, boss, shot;
    logic [7:0] boss_hp;
    logic [5:0] slot_busy;
    logic       fire_fan, fire_big, invuln, game_over;
    logic [1:0] phase;
    logic [2:0] life;

    always #5 clk22 = ~clk22;

    boss_attack_ctrl #(
        .FAN_PERIOD(FAN_P), .BIG_PERIOD(BIG_P), .INVULN_TICKS(INV_T), .LIVES(NLIFE)
    ) dut (
        .clk22(clk22), .rst(rst), .boss(boss), .boss_hp(boss_hp), .slot_busy(slot_busy),
        .shot(shot), .fire_fan(fire_fan), .fire_big(fire_big), .phase(phase),
        .invuln(invuln), .life(life), .game_over(game_over)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fan_q[$];
    int big_q[$];

    // Reference model: mode 0 idle, 1 run, 2 over; ages count run ticks since the last launch.
    int m_mode, m_age_f, m_age_b, m_tgt_f, m_tgt_b, m_phase, m_inv_left, m_life;
    bit m_go, m_ff, m_fb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int eff(input int base, input int ph);
`ifdef BOSS_ATTACK_ENRAGE_EN
        if (ph == 2) return (base / 2 < 1) ? 1 : base / 2;
`endif
        return base;
    endfunction

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit b, input int hp, input bit [5:0] sb, input bit sh);
        bit vuln, fan_ok, big_ok;
        int new_phase;
        new_phase = (hp >= 128) ? 0 : (hp >= 64) ? 1 : 2;
        m_ff = 0;
        m_fb = 0;
        if (r) begin
            m_mode = 0; m_age_f = 0; m_age_b = 0; m_tgt_f = FAN_P; m_tgt_b = BIG_P;
            m_phase = 0; m_inv_left = 0; m_life = NLIFE; m_go = 0;
            return;
        end
        vuln = (m_inv_left == 0);
        if (m_inv_left > 0) m_inv_left--;
        if (m_mode == 0) begin
            if (b) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!b) begin
                m_mode = 0; m_age_f = 0; m_age_b = 0; m_tgt_f = FAN_P; m_tgt_b = BIG_P;
                m_inv_left = 0;
            end else begin
                if (sh && vuln && m_life > 0) begin
                    m_life--;
                    m_inv_left = INV_T;
                    if (m_life == 0) begin
                        m_mode = 2;
                        m_go = 1;
                    end
                end
                fan_ok = (m_age_f >= m_tgt_f - 1) && (sb[5:1] == 0);
                big_ok = (m_phase >= 1) && (m_age_b >= m_tgt_b - 1) && !sb[0] && !fan_ok;
                m_age_f++;
                m_age_b++;
                if (m_mode == 1 && fan_ok) begin
                    m_ff = 1; m_age_f = 0; m_tgt_f = eff(FAN_P, m_phase);
                end
                if (m_mode == 1 && big_ok) begin
                    m_fb = 1; m_age_b = 0; m_tgt_b = eff(BIG_P, m_phase);
                end
            end
        end
        m_phase = new_phase;
    endtask

    task automatic drive(input bit r, input bit b, input int hp, input bit [5:0] sb, input bit sh);
        rst = r; boss = b; boss_hp = hp[7:0]; slot_busy = sb; shot = sh;
        model_step(r, b, hp, sb, sh);
        @(posedge clk22);
        @(negedge clk22);
        check("fire_fan", fire_fan, m_ff);
        check("fire_big", fire_big, m_fb);
        check("phase", phase, m_phase);
        check("invuln", invuln, m_inv_left > 0);
        check("life", life, m_life);
        check("game_over", game_over, m_go);
        if (fire_fan) fan_q.push_back(cyc);
        if (fire_big) big_q.push_back(cyc);
        cyc++;
    endtask

    task automatic seg(input int n, input bit b, input int hp, input bit [5:0] sb, input bit sh);
        for (int i = 0; i < n; i++) drive(0, b, hp, sb, sh);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        fan_q.delete();
        big_q.delete();
        cyc = 0;
    endtask

    initial begin
        rst = 1; boss = 0; boss_hp = 0; slot_busy = 0; shot = 0;

        // Reset values, then phase 0: fan every 8 ticks, no big bullet.
        do_reset();
        check("rst_life", life, 3);
        check("rst_phase", phase, 0);
        seg(41, 1, 200, 6'd0, 0);
        check("p0_fan_count", fan_q.size(), 5);
        check("p0_fan_first", qget(fan_q, 0), 8);
        check("p0_fan_gap", qget(fan_q, 1) - qget(fan_q, 0), 8);
        check("p0_big_count", big_q.size(), 0);

        // Phase 1: big bullet collides with a fan volley at tick 24 and slips one tick.
        do_reset();
        seg(60, 1, 100, 6'd0, 0);
        check("p1_big_first", qget(big_q, 0), 25);
        check("p1_big_gap", qget(big_q, 1) - qget(big_q, 0), 24);
        check("p1_fan_at_24", qget(fan_q, 2), 24);

        // Fan due while slot 1 is busy for five ticks: exactly one late launch.
        do_reset();
        seg(8, 1, 200, 6'd0, 0);
        seg(5, 1, 200, 6'b000010, 0);
        seg(5, 1, 200, 6'd0, 0);
        check("busy_fan_count", fan_q.size(), 1);
        check("busy_fan_tick", qget(fan_q, 0), 13);

        // Shots at relative ticks 0, 5, 20.
        do_reset();
        seg(2, 1, 200, 6'd0, 0);
        for (int i = 0; i < 30; i++) begin
            drive(0, 1, 200, 6'd0, (i == 0) || (i == 5) || (i == 20));
            if (i == 0)  check("shot0_life", life, 2);
            if (i == 6)  check("shot5_ignored", life, 2);
            if (i == 15) check("inv_still_on", invuln, 1);
            if (i == 16) check("inv_cleared", invuln, 0);
        end
        check("shot20_life", life, 1);

        // Three spaced shots end the game; nothing fires afterwards; reset recovers.
        do_reset();
        seg(2, 1, 100, 6'd0, 0);
        for (int i = 0; i < 45; i++) drive(0, 1, 100, 6'd0, (i == 0) || (i == 20) || (i == 40));
        check("over_life", life, 0);
        check("over_flag", game_over, 1);
        fan_q.delete();
        big_q.delete();
        seg(30, 1, 100, 6'd0, 1);
        check("over_no_fan", fan_q.size(), 0);
        check("over_no_big", big_q.size(), 0);
        drive(1, 1, 100, 6'd0, 0);
        check("over_rst_life", life, 3);
        check("over_rst_flag", game_over, 0);

        // Phase 2 periods depend on the enrage build option.
        do_reset();
        seg(60, 1, 40, 6'd0, 0);
        check("p2_fan_gap", qget(fan_q, 2) - qget(fan_q, 1), EXP_FAN_GAP2);
        check("p2_big_gap", qget(big_q, 1) - qget(big_q, 0), EXP_BIG_GAP2);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit [5:0] sb;
            for (int k = 0; k < 6; k++) sb[k] = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 399) == 0, $urandom_range(0, 49) != 0,
                  int'($urandom_range(0, 255)), sb, $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
